// File: rtl/multicycle_pkg.sv
// Shared types and helpers for the multicycle LEGv8 core.
// Holds the FSM state enum, opcode constants, ALU control codes,
// sign-extend select codes, fault codes, and the ALU / sign-extender
// helper functions used by the datapath.
package multicycle_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEM, WB, FAULT
  } state_e;

  typedef enum logic [3:0] {
    OP_LDUR, OP_STUR, OP_ADD, OP_SUB, OP_AND, OP_ORR,
    OP_CBZ, OP_B, OP_MOVZ, OP_ILLEGAL
  } op_e;

  // Full 11-bit opcodes and the fixed prefixes of the shorter encodings.
  localparam logic [10:0] OPC_LDUR      = 11'b11111000010;
  localparam logic [10:0] OPC_STUR      = 11'b11111000000;
  localparam logic [10:0] OPC_ADD       = 11'b10001011000;
  localparam logic [10:0] OPC_SUB       = 11'b11001011000;
  localparam logic [10:0] OPC_AND       = 11'b10001010000;
  localparam logic [10:0] OPC_ORR       = 11'b10101010000;
  localparam logic [7:0]  OPC_CBZ_PFX   = 8'b10110100;
  localparam logic [5:0]  OPC_B_PFX     = 6'b000101;
  localparam logic [8:0]  OPC_MOVZ_PFX  = 9'b110100101;

  localparam logic [4:0]  XZR = 5'd31;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_PASSB
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    SE_D,   // imm9  IR[20:12]
    SE_CB,  // imm19 IR[23:5]
    SE_B,   // imm26 IR[25:0]
    SE_IW   // imm16 IR[20:5] shifted by hw*16, zero-extended
  } se_sel_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ILLEGAL = 2'b01,
    FC_TIMEOUT = 2'b10
  } fault_code_e;

  function automatic op_e decode_op(input logic [10:0] opc);
    op_e op;
    op = OP_ILLEGAL;
    if      (opc == OPC_LDUR)              op = OP_LDUR;
    else if (opc == OPC_STUR)              op = OP_STUR;
    else if (opc == OPC_ADD)               op = OP_ADD;
    else if (opc == OPC_SUB)               op = OP_SUB;
    else if (opc == OPC_AND)               op = OP_AND;
    else if (opc == OPC_ORR)               op = OP_ORR;
    else if (opc[10:3] == OPC_CBZ_PFX)     op = OP_CBZ;
    else if (opc[10:5] == OPC_B_PFX)       op = OP_B;
    else if (opc[10:2] == OPC_MOVZ_PFX)    op = OP_MOVZ;
    return op;
  endfunction

  function automatic alu_ctrl_e alu_ctrl_of(input op_e op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_ORR:  return ALU_ORR;
      OP_MOVZ: return ALU_PASSB;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic se_sel_e se_sel_of(input op_e op);
    case (op)
      OP_CBZ:  return SE_CB;
      OP_B:    return SE_B;
      OP_MOVZ: return SE_IW;
      default: return SE_D;
    endcase
  endfunction

  function automatic logic [63:0] sign_extend(input se_sel_e sel, input logic [31:0] ir);
    case (sel)
      SE_CB:   return {{45{ir[23]}}, ir[23:5]};
      SE_B:    return {{38{ir[25]}}, ir[25:0]};
      SE_IW:   return 64'(ir[20:5]) << {ir[22:21], 4'b0000};
      default: return {{55{ir[20]}}, ir[20:12]};
    endcase
  endfunction

  function automatic logic [63:0] alu(input alu_ctrl_e ctrl, input logic [63:0] a,
                                      input logic [63:0] b);
    case (ctrl)
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_ORR:   return a | b;
      ALU_PASSB: return b;
      default:   return a + b;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_regfile.sv
// 32 x 64-bit register file: two asynchronous read ports, one write port
// updated on the rising clock edge. X31 is hard-wired to zero.
// Ports:
//   clk_i              clock
//   we_i/waddr_i/wdata_i  write port (writes to X31 are dropped)
//   raddr1_i/rdata1_o  read port 1
//   raddr2_i/rdata2_o  read port 2
module multicycle_regfile
  import multicycle_pkg::*;
(
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [63:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  output logic [63:0] rdata1_o,
  input  logic [4:0]  raddr2_i,
  output logic [63:0] rdata2_o
);

  logic [63:0] regs_q [0:31];

  // NOTE: the storage array has no reset; architectural registers survive a
  // core reset, and leaving it out keeps this a plain RAM-style array.
  // Non-blocking assignment is used because this is clocked state.
  always_ff @(posedge clk_i) begin
    if (we_i && waddr_i != XZR) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == XZR) ? 64'd0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == XZR) ? 64'd0 : regs_q[raddr2_i];

endmodule

// File: rtl/multicycle_proc.sv
// Multicycle LEGv8 core with one shared req/ack memory port for fetch and
// data. Each instruction walks FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB).
// Illegal opcodes and bus timeouts park the core in a sticky FAULT state.
// Optional macro MULTICYCLE_PERF_EN adds cycle_count / instr_count outputs.
// Ports:
//   CLK, resetl         clock, async active-low reset
//   startpc             PC loaded on the first cycle after reset release
//   currentpc, dmemout  architectural PC, last register write-back value
//   mem_req/we/addr/wdata, mem_rdata, mem_ack   unified memory handshake
//   retire              one-cycle pulse per completed instruction
//   fault, fault_code   sticky fault flag and cause
module multicycle_proc
  import multicycle_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic [63:0]       startpc,
  output logic [63:0]       currentpc,
  output logic [63:0]       dmemout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              retire,
  output logic              fault,
  output logic [1:0]        fault_code
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [31:0]       cycle_count,
  output logic [31:0]       instr_count
`endif
);

  state_e            state_q;
  op_e               op_q;
  logic [63:0]       pc_q, a_q, b_q, imm_q, alu_out_q, mdr_q, dmemout_q, mem_wdata_q;
  logic [31:0]       ir_q, tmo_q;
  logic              mem_req_q, mem_we_q, retire_q, fault_q;
  logic [ADDR_W-1:0] mem_addr_q;
  fault_code_e       fault_code_q;

  op_e         op_dec;
  logic [4:0]  rd2_addr;
  logic [63:0] rdata1, rdata2, imm_dec, alu_b, alu_res;
  logic [63:0] pc_plus4, exec_pc, wb_data, wb_pc;
  logic        timeout_hit;

  // NOTE: every always_comb output gets a value on every path (here by
  // unconditional assignment) so no latch is inferred.
  always_comb begin
    op_dec   = decode_op(ir_q[31:21]);
    // STUR and CBZ read their second operand from the Rt field.
    rd2_addr = (op_dec == OP_STUR || op_dec == OP_CBZ) ? ir_q[4:0] : ir_q[20:16];
    imm_dec  = sign_extend(se_sel_of(op_dec), ir_q);
    alu_b    = (op_q inside {OP_LDUR, OP_STUR, OP_MOVZ}) ? imm_q : b_q;
    alu_res  = alu(alu_ctrl_of(op_q), a_q, alu_b);
    pc_plus4 = pc_q + 64'd4;
    exec_pc  = (op_q == OP_B || (op_q == OP_CBZ && b_q == 64'd0))
               ? pc_q + (imm_q << 2) : pc_plus4;
    wb_data  = (op_q == OP_LDUR) ? mdr_q : alu_out_q;
    // R-type/MOVZ already advanced the PC in EXECUTE; loads advance here.
    wb_pc    = (op_q == OP_LDUR) ? pc_plus4 : pc_q;
    timeout_hit = (MEM_TIMEOUT != 0) && (tmo_q == 32'(MEM_TIMEOUT - 1));
  end

  multicycle_regfile u_regfile (
    .clk_i    (CLK),
    .we_i     (state_q == WB),
    .waddr_i  (ir_q[4:0]),
    .wdata_i  (wb_data),
    .raddr1_i (ir_q[9:5]),
    .rdata1_o (rdata1),
    .raddr2_i (rd2_addr),
    .rdata2_o (rdata2)
  );

  // Outputs are registered: every transition into FETCH/MEM also sets up the
  // request so mem_req is high in the very first cycle of those states.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q      <= IDLE;
      op_q         <= OP_ADD;
      pc_q         <= '0;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
      alu_out_q    <= '0;
      mdr_q        <= '0;
      tmo_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      retire_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      dmemout_q    <= '0;
    end else begin
      retire_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          pc_q       <= startpc;
          state_q    <= FETCH;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= ADDR_W'(startpc);
          tmo_q      <= '0;
        end
        FETCH: begin
          if (mem_ack) begin
            ir_q      <= mem_rdata[31:0];
            mem_req_q <= 1'b0;
            state_q   <= DECODE;
          end else if (timeout_hit) begin
            mem_req_q    <= 1'b0;
            fault_q      <= 1'b1;
            fault_code_q <= FC_TIMEOUT;
            state_q      <= FAULT;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        DECODE: begin
          if (op_dec == OP_ILLEGAL) begin
            fault_q      <= 1'b1;
            fault_code_q <= FC_ILLEGAL;
            state_q      <= FAULT;
          end else begin
            a_q     <= rdata1;
            b_q     <= rdata2;
            imm_q   <= imm_dec;
            op_q    <= op_dec;
            state_q <= EXECUTE;
          end
        end
        EXECUTE: begin
          alu_out_q <= alu_res;
          if (op_q == OP_B || op_q == OP_CBZ) begin
            pc_q       <= exec_pc;
            retire_q   <= 1'b1;
            state_q    <= FETCH;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= ADDR_W'(exec_pc);
            tmo_q      <= '0;
          end else if (op_q == OP_LDUR || op_q == OP_STUR) begin
            state_q     <= MEM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= (op_q == OP_STUR);
            mem_addr_q  <= ADDR_W'(alu_res);
            mem_wdata_q <= b_q;
            tmo_q       <= '0;
          end else begin
            pc_q    <= pc_plus4;
            state_q <= WB;
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_we_q <= 1'b0;
            if (op_q == OP_STUR) begin
              pc_q       <= pc_plus4;
              retire_q   <= 1'b1;
              state_q    <= FETCH;
              mem_req_q  <= 1'b1;
              mem_addr_q <= ADDR_W'(pc_plus4);
              tmo_q      <= '0;
            end else begin
              mdr_q     <= mem_rdata;
              mem_req_q <= 1'b0;
              state_q   <= WB;
            end
          end else if (timeout_hit) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            fault_q      <= 1'b1;
            fault_code_q <= FC_TIMEOUT;
            state_q      <= FAULT;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        WB: begin
          dmemout_q  <= wb_data;
          pc_q       <= wb_pc;
          retire_q   <= 1'b1;
          state_q    <= FETCH;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= ADDR_W'(wb_pc);
          tmo_q      <= '0;
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: begin
          state_q <= FAULT;
        end
      endcase
    end
  end

  assign currentpc  = pc_q;
  assign dmemout    = dmemout_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign retire     = retire_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_count_q, instr_count_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      if (state_q != IDLE && state_q != FAULT && cycle_count_q != 32'hFFFF_FFFF) begin
        cycle_count_q <= cycle_count_q + 32'd1;
      end
      if (retire_q && instr_count_q != 32'hFFFF_FFFF) begin
        instr_count_q <= instr_count_q + 32'd1;
      end
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_proc.sv
// Directed bench for multicycle_proc with a byte-addressed memory model of
// configurable ack latency. Programs: MOVZ/ADD then illegal opcode, STUR/LDUR
// with 3-cycle memory, CBZ/B branching, bus timeout, and reset mid-MEM.
module tb_multicycle_proc;

  logic        clk = 1'b0;
  logic        resetl = 1'b0;
  logic [63:0] startpc = '0;
  logic [63:0] currentpc, dmemout, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_ack, retire, fault;
  logic [1:0]  fault_code;
`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  always #5 clk = ~clk;

  multicycle_proc #(.ADDR_W(64), .MEM_TIMEOUT(4)) dut (
    .CLK        (clk),
    .resetl     (resetl),
    .startpc    (startpc),
    .currentpc  (currentpc),
    .dmemout    (dmemout),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .retire     (retire),
    .fault      (fault),
    .fault_code (fault_code)
`ifdef MULTICYCLE_PERF_EN
    ,
    .cycle_count(cycle_count),
    .instr_count(instr_count)
`endif
  );

  // ---------------- memory model ----------------
  logic [7:0]  mem [0:255];
  int          latency = 1;
  bit          ack_off = 1'b0;
  logic        model_ack = 1'b0, stray_ack = 1'b0;
  int          wait_cnt = 0, wr_count = 0, wr_len = 0;
  logic [63:0] wr_addr = '0, wr_data = '0;
  logic [7:0]  idx;

  initial mem_rdata = '0;
  assign mem_ack = model_ack | stray_ack;

  // Decides the ack for the current cycle at the falling edge, so the DUT
  // sees a stable ack/rdata at the next rising edge.
  always @(negedge clk) begin
    model_ack = 1'b0;
    if (mem_req && !ack_off) begin
      wait_cnt++;
      if (wait_cnt >= latency) begin
        model_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
          idx = mem_addr[7:0] + 8'(i);
          mem_rdata[8*i +: 8] = mem[idx];
          if (mem_we) mem[idx] = mem_wdata[8*i +: 8];
        end
        if (mem_we) begin
          wr_addr = mem_addr;
          wr_data = mem_wdata;
          wr_len  = wait_cnt;
          wr_count++;
        end
        wait_cnt = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic put32(input int addr, input logic [31:0] val);
    for (int i = 0; i < 4; i++) mem[addr + i] = val[8*i +: 8];
  endtask

  // ---------------- checking ----------------
  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- observation ----------------
  int          rt_c[$];
  logic [63:0] rt_pc[$], rt_dm[$];
  int          req_cycles;
  logic [63:0] pc0;
  logic        req0;

  // Cycle 0 is the first FETCH cycle; samples on the falling edge.
  task automatic observe(input int n);
    rt_c.delete(); rt_pc.delete(); rt_dm.delete();
    req_cycles = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0) begin pc0 = currentpc; req0 = mem_req; end
      if (mem_req) req_cycles++;
      if (retire) begin rt_c.push_back(c); rt_pc.push_back(currentpc); rt_dm.push_back(dmemout); end
    end
  endtask

  function automatic logic [63:0] q_c(input int i);
    return (i < rt_c.size()) ? 64'(rt_c[i]) : '1;
  endfunction
  function automatic logic [63:0] q_pc(input int i);
    return (i < rt_pc.size()) ? rt_pc[i] : '1;
  endfunction
  function automatic logic [63:0] q_dm(input int i);
    return (i < rt_dm.size()) ? rt_dm[i] : '1;
  endfunction

  task automatic do_reset(input logic [63:0] pc, input int lat);
    @(negedge clk);
    resetl   = 1'b0;
    startpc  = pc;
    latency  = lat;
    ack_off  = 1'b0;
    wr_count = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench just after the IDLE -> FETCH edge.
  task automatic release_reset();
    resetl = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    put32(32'h00, 32'hD28000A1);  // MOVZ X1,#5
    put32(32'h04, 32'h8B010022);  // ADD  X2,X1,X1
    put32(32'h10, 32'hB400005F);  // CBZ  X31,+2
    put32(32'h18, 32'hB4000041);  // CBZ  X1,+2 (not taken)
    put32(32'h1C, 32'h17FFFFFF);  // B    -1
    put32(32'h40, 32'hF80083E2);  // STUR X2,[X31,#8]
    put32(32'h44, 32'hF84083E3);  // LDUR X3,[X31,#8]

    // ---- run 1: zero-wait MOVZ/ADD, then opcode 0 at 0x08 ----
    do_reset(64'h0, 1);
    check("rst_pc", currentpc, 64'h0);
    check("rst_req", {63'd0, mem_req}, 64'd0);
    check("rst_retire", {63'd0, retire}, 64'd0);
    check("rst_fault", {63'd0, fault}, 64'd0);
    check("rst_dmemout", dmemout, 64'd0);
    release_reset();
    observe(16);
    check("r1_pc0", pc0, 64'h0);
    check("r1_req0", {63'd0, req0}, 64'd1);
    check("r1_nret", 64'(rt_c.size()), 64'd2);
    check("r1_ret0_cyc", q_c(0), 64'd4);
    check("r1_ret1_cyc", q_c(1), 64'd8);
    check("r1_movz_wb", q_dm(0), 64'd5);
    check("r1_add_wb", q_dm(1), 64'd10);
    check("r1_ret1_pc", q_pc(1), 64'h8);
    check("r1_fault", {63'd0, fault}, 64'd1);
    check("r1_fault_code", {62'd0, fault_code}, 64'd1);
    check("r1_pc_frozen", currentpc, 64'h8);
    check("r1_req_low", {63'd0, mem_req}, 64'd0);

    // ---- run 2: STUR/LDUR with 3-cycle ack latency ----
    do_reset(64'h40, 3);
    check("r2_rst_pc", currentpc, 64'h0);
    check("r2_rst_fault", {63'd0, fault}, 64'd0);
    check("r2_rst_code", {62'd0, fault_code}, 64'd0);
    release_reset();
    observe(26);
    check("r2_pc0", pc0, 64'h40);
    check("r2_nret", 64'(rt_c.size()), 64'd2);
    check("r2_stur_cyc", q_c(0), 64'd8);
    check("r2_ldur_cyc", q_c(1), 64'd17);
    check("r2_stur_pc", q_pc(0), 64'h44);
    check("r2_ldur_pc", q_pc(1), 64'h48);
    check("r2_ldur_wb", q_dm(1), 64'd10);
    check("r2_wr_count", 64'(wr_count), 64'd1);
    check("r2_wr_addr", wr_addr, 64'd8);
    check("r2_wr_data", wr_data, 64'd10);
    check("r2_wr_len", 64'(wr_len), 64'd3);
    check("r2_req_cycles", 64'(req_cycles), 64'd15);

    // ---- run 3: CBZ taken, CBZ not taken, backward B ----
    do_reset(64'h10, 1);
    release_reset();
    observe(10);
    check("r3_nret", 64'(rt_c.size()), 64'd3);
    check("r3_cbz_cyc", q_c(0), 64'd3);
    check("r3_cbz_taken_pc", q_pc(0), 64'h18);
    check("r3_cbz_nt_pc", q_pc(1), 64'h1C);
    check("r3_b_back_pc", q_pc(2), 64'h18);
    check("r3_no_wb", dmemout, 64'd0);

    // ---- run 4: no ack at all -> bus timeout ----
    do_reset(64'h0, 1);
    ack_off = 1'b1;
    release_reset();
    observe(8);
    check("r4_req_cycles", 64'(req_cycles), 64'd4);
    check("r4_fault", {63'd0, fault}, 64'd1);
    check("r4_fault_code", {62'd0, fault_code}, 64'd2);
    check("r4_pc_frozen", currentpc, 64'h0);
    check("r4_nret", 64'(rt_c.size()), 64'd0);
    ack_off = 1'b0;

    // ---- run 5: reset asserted during the STUR MEM wait ----
    do_reset(64'h40, 3);
    release_reset();
    repeat (7) @(negedge clk);
    check("r5_mem_req", {63'd0, mem_req}, 64'd1);
    check("r5_mem_we", {63'd0, mem_we}, 64'd1);
    #2 resetl = 1'b0;
    #1;
    check("r5_async_req", {63'd0, mem_req}, 64'd0);
    check("r5_async_we", {63'd0, mem_we}, 64'd0);
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    check("r5_rst_pc", currentpc, 64'h0);
    check("r5_no_write", 64'(wr_count), 64'd0);
    resetl = 1'b1;
    @(posedge clk);
    #1 stray_ack = 1'b0;
    observe(12);
    check("r5_pc0", pc0, 64'h40);
    check("r5_stur_cyc", q_c(0), 64'd8);
    check("r5_stur_pc", q_pc(0), 64'h44);
    check("r5_wr_count", 64'(wr_count), 64'd1);
    check("r5_wr_addr", wr_addr, 64'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
